// File: rtl/hs_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hs_spi_pkg
//  Purpose  : Shared types and helpers for the high-speed SPI transaction
//             sequencer: FSM state encoding, header field positions, header
//             builder and the busy-fall frame-end predicate.
//  Revision : 1.0 - initial release
// ============================================================================
package hs_spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_LOAD  = 3'd1,
        HDR_WAIT  = 3'd2,
        GAP       = 3'd3,
        DATA_LOAD = 3'd4,
        DATA_WAIT = 3'd5,
        RESP      = 3'd6
    } state_t;

    // Widest frame the header builder supports; callers cast down to DW.
    localparam int HDR_MAX_W = 64;

    // Header fields are placed relative to the frame MSB so the layout holds
    // for any DW: wr sits at bit DW-WR_BIT_OFS, the address MSB at
    // bit DW-ADDR_MSB_OFS, and everything below the address is zero.
    localparam int WR_BIT_OFS   = 1;
    localparam int ADDR_MSB_OFS = 2;

    function automatic logic [HDR_MAX_W-1:0] make_header(
        input logic                 wr,
        input logic [HDR_MAX_W-1:0] addr,
        input int                   dw,
        input int                   aw
    );
        logic [HDR_MAX_W-1:0] hdr;
        hdr = '0;
        hdr[dw-WR_BIT_OFS] = wr;
        // Address LSB lands at dw-ADDR_MSB_OFS-(aw-1) = dw-1-aw.
        hdr = hdr | (addr << (dw - ADDR_MSB_OFS + 1 - aw));
        return hdr;
    endfunction

    // A frame has ended when busy was high last cycle and is low now.
    function automatic logic frame_end(input logic busy_q, input logic busy);
        return busy_q & ~busy;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hs_spi_txn_ctrl_frame_issue.sv
`default_nettype none
// ============================================================================
//  Module   : hs_spi_frame_issue
//  Purpose  : Issues one SPI frame to the master: presents load/data_in while
//             enabled, flags the accepted cycle (load & empty) and detects the
//             end of the frame from the falling edge of busy.
//  Ports    : clk, rst        - clock / synchronous active-high reset
//             load_en         - caller is in a load state
//             word            - frame word to present
//             spi_empty/busy  - master status
//             spi_load        - master load strobe
//             spi_data_in     - master data_in (zero when not loading)
//             accepted        - load taken by the master this cycle
//             frame_done      - busy fell this cycle
//  Revision : 1.0 - initial release
// ============================================================================
module hs_spi_frame_issue
    import hs_spi_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [DW-1:0] word,
    input  logic          spi_empty,
    input  logic          spi_busy,
    output logic          spi_load,
    output logic [DW-1:0] spi_data_in,
    output logic          accepted,
    output logic          frame_done
);

    logic r_busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy_q <= 1'b0;
        end else begin
            r_busy_q <= spi_busy;
        end
    end

    // Load stays up for the whole load state; the master only takes it on a
    // cycle where it reports empty, and the caller leaves the load state on
    // exactly that cycle, so a single frame is issued.
    assign spi_load    = load_en;
    assign spi_data_in = load_en ? word : '0;
    assign accepted    = load_en & spi_empty;
    assign frame_done  = frame_end(r_busy_q, spi_busy);

endmodule
`default_nettype wire

// File: rtl/hs_spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hs_spi_txn_ctrl
//  Purpose  : Register read/write sequencer in front of the high-speed SPI
//             master. Each request becomes a header frame followed (after
//             GAP_CYCLES idle cycles) by a data frame; the word returned in
//             the data frame is reported on the response stream.
//  Ports    : clk, rst                          - clock / sync active-high reset
//             req_valid/ready/wr/addr/wdata     - request stream
//             rsp_valid/ready/rdata/err         - response stream
//             spi_load/empty/busy/data_in/out   - SPI master interface
//  Options  : HS_SPI_TXN_TIMEOUT_EN - per-frame watchdog of TIMEOUT cycles;
//             on expiry the response carries rsp_err=1 and rsp_rdata=0.
//  Revision : 1.0 - initial release
// ============================================================================
module hs_spi_txn_ctrl #(
    parameter int DW         = 32,
    parameter int AW         = 15,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          spi_load,
    input  logic          spi_empty,
    input  logic          spi_busy,
    output logic [DW-1:0] spi_data_in,
    input  logic [DW-1:0] spi_data_out
);

    import hs_spi_pkg::*;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t        r_state;
    state_t        w_state_next;
    logic          r_wr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic [GW-1:0] r_gap_cnt;

    logic          w_load_en;
    logic [DW-1:0] w_header;
    logic [DW-1:0] w_data_word;
    logic [DW-1:0] w_word;
    logic          w_accepted;
    logic          w_frame_done;
    logic          w_gap_last;
    logic          w_wd_expired;
    logic          w_abort;

    // ------------------------------------------------------------------
    // Frame words
    // ------------------------------------------------------------------
    assign w_header    = DW'(make_header(r_wr, HDR_MAX_W'(r_addr), DW, AW));
    assign w_data_word = r_wr ? r_wdata : '0;
    assign w_word      = (r_state == DATA_LOAD) ? w_data_word : w_header;
    assign w_load_en   = (r_state == HDR_LOAD) || (r_state == DATA_LOAD);
    assign w_gap_last  = (r_gap_cnt == GW'(GAP_CYCLES - 1));

    hs_spi_frame_issue #(
        .DW (DW)
    ) u_frame_issue (
        .clk         (clk),
        .rst         (rst),
        .load_en     (w_load_en),
        .word        (w_word),
        .spi_empty   (spi_empty),
        .spi_busy    (spi_busy),
        .spi_load    (spi_load),
        .spi_data_in (spi_data_in),
        .accepted    (w_accepted),
        .frame_done  (w_frame_done)
    );

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef HS_SPI_TXN_TIMEOUT_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [WDW-1:0] r_wd_cnt;

    // Restarts on every state change, so each load/wait state gets its own
    // TIMEOUT-cycle budget measured from its entry cycle.
    always_ff @(posedge clk) begin
        if (rst || (w_state_next != r_state)) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_expired = (r_wd_cnt == WDW'(TIMEOUT - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_wd_expired     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_state_next = HDR_LOAD;
                end
            end
            HDR_LOAD: begin
                if (w_accepted) begin
                    w_state_next = HDR_WAIT;
                end else if (w_wd_expired) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            HDR_WAIT: begin
                // The header's receive word carries nothing useful.
                if (w_frame_done) begin
                    w_state_next = (GAP_CYCLES == 0) ? DATA_LOAD : GAP;
                end else if (w_wd_expired) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            GAP: begin
                if (w_gap_last) begin
                    w_state_next = DATA_LOAD;
                end
            end
            DATA_LOAD: begin
                if (w_accepted) begin
                    w_state_next = DATA_WAIT;
                end else if (w_wd_expired) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            DATA_WAIT: begin
                if (w_frame_done) begin
                    w_state_next = RESP;
                end else if (w_wd_expired) begin
                    w_state_next = RESP;
                    w_abort      = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            if ((r_state == IDLE) && req_valid) begin
                r_wr    <= req_wr;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end

            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end else begin
                r_gap_cnt <= '0;
            end

            // Master data_out is valid in the cycle busy falls.
            if ((r_state == DATA_WAIT) && w_frame_done) begin
                r_rdata <= r_wr ? '0 : spi_data_out;
                r_err   <= 1'b0;
            end else if (w_abort) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    // req_ready is masked by rst so nothing is offered while reset is held.
    assign req_ready = (r_state == IDLE) & ~rst;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hs_spi_txn_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hs_spi_txn_ctrl
//  Purpose  : Directed self-checking bench for hs_spi_txn_ctrl with a
//             behavioural SPI master (fixed frame length, frame log).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hs_spi_txn_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 15;
    localparam int GAP   = 4;
    localparam int TMO   = 64;
    localparam int FRAME = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          spi_load;
    logic          spi_empty;
    logic          spi_busy;
    logic [DW-1:0] spi_data_in;
    logic [DW-1:0] spi_data_out;

    always #5 clk = ~clk;

    hs_spi_txn_ctrl #(
        .DW         (DW),
        .AW         (AW),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .spi_load     (spi_load),
        .spi_empty    (spi_empty),
        .spi_busy     (spi_busy),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out)
    );

    // ------------------------------------------------------------------
    // SPI master model
    // ------------------------------------------------------------------
    logic          m_busy      = 1'b0;
    int            m_cnt       = 0;
    logic          stall_empty = 1'b0;
    logic          stuck_busy  = 1'b0;
    logic [DW-1:0] slave_resp  = '0;
    int            cyc         = 0;
    int            nfrm        = 0;
    logic [DW-1:0] frm_word [0:31];
    int            frm_acc  [0:31];
    int            frm_end  [0:31];

    assign spi_empty = ~m_busy & ~stall_empty;
    assign spi_busy  = m_busy | stuck_busy;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy       <= 1'b0;
            m_cnt        <= 0;
            spi_data_out <= '0;
        end else if (!m_busy) begin
            if (spi_load && spi_empty) begin
                frm_word[nfrm] <= spi_data_in;
                frm_acc[nfrm]  <= cyc;
                m_busy         <= 1'b1;
                m_cnt          <= FRAME - 1;
                spi_data_out   <= 32'h0BAD0BAD;
            end
        end else if (m_cnt == 0) begin
            m_busy        <= 1'b0;
            spi_data_out  <= slave_resp;
            frm_end[nfrm] <= cyc + 1;
            nfrm          <= nfrm + 1;
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int n_chk = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 100 && !req_ready; i++) tick();
        chkb("req_ready_seen", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound);
        for (int i = 0; i < bound && !rsp_valid; i++) tick();
        chkb("rsp_valid_seen", rsp_valid, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int  base;
        int  t_rsp;
        logic seen;

        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) tick();

        // Reset values
        chkb("rst_req_ready", req_ready, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_rsp_err", rsp_err, 1'b0);
        chkb("rst_spi_load", spi_load, 1'b0);
        chk ("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk ("rst_spi_data_in", spi_data_in, 32'h0);
        rst = 1'b0;
        tick();
        chkb("idle_req_ready", req_ready, 1'b1);

        // Write 0x1234 <- 0xDEADBEEF
        base = nfrm; slave_resp = 32'h0;
        send_req(1'b1, 15'h1234, 32'hDEADBEEF);
        chkb("wr_busy_req_ready", req_ready, 1'b0);
        wait_rsp(200);
        chk ("wr_rdata", rsp_rdata, 32'h0);
        chkb("wr_err", rsp_err, 1'b0);
        chk ("wr_nfrm", nfrm - base, 2);
        chk ("wr_hdr", frm_word[base], 32'h92340000);
        chk ("wr_data", frm_word[base+1], 32'hDEADBEEF);
        chk ("wr_gap", frm_acc[base+1] - frm_end[base] - 1, GAP);
        tick();
        chkb("wr_rsp_done", rsp_valid, 1'b0);
        chkb("wr_ready_back", req_ready, 1'b1);

        // Read 0x0007 -> 0xCAFEF00D (wdata must be ignored)
        base = nfrm; slave_resp = 32'hCAFEF00D;
        send_req(1'b0, 15'h0007, 32'h12345678);
        wait_rsp(200);
        chk ("rd_rdata", rsp_rdata, 32'hCAFEF00D);
        chkb("rd_err", rsp_err, 1'b0);
        chk ("rd_hdr", frm_word[base], 32'h00070000);
        chk ("rd_data", frm_word[base+1], 32'h00000000);
        tick();

        // Back-to-back with rsp_ready low for 10 cycles
        rsp_ready = 1'b0; base = nfrm; slave_resp = 32'h13572468;
        send_req(1'b0, 15'h0005, 32'h0);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 15'h7FFF; req_wdata = 32'h5A5A5A5A;
        wait_rsp(200);
        for (int i = 0; i < 10; i++) begin
            chkb("hold_valid", rsp_valid, 1'b1);
            chk ("hold_rdata", rsp_rdata, 32'h13572468);
            chkb("hold_req_blocked", req_ready, 1'b0);
            tick();
        end
        chk ("b2b_first_hdr", frm_word[base], 32'h00050000);
        rsp_ready = 1'b1;
        tick();
        chkb("b2b_rsp_done", rsp_valid, 1'b0);
        chkb("b2b_ready_after_hs", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chkb("b2b_second_taken", req_ready, 1'b0);
        wait_rsp(200);
        chk ("b2b_wr_rdata", rsp_rdata, 32'h0);
        chk ("b2b_nfrm", nfrm - base, 4);
        chk ("b2b_hdr_maxaddr", frm_word[base+2], 32'hFFFF0000);
        chk ("b2b_data", frm_word[base+3], 32'h5A5A5A5A);
        tick();

        // Master not empty for 20 cycles: load held, header stable
        stall_empty = 1'b1; base = nfrm; slave_resp = 32'h11112222;
        send_req(1'b0, 15'h0001, 32'h0);
        for (int i = 0; i < 20; i++) begin
            chkb("stall_load", spi_load, 1'b1);
            chk ("stall_hdr", spi_data_in, 32'h00010000);
            tick();
        end
        stall_empty = 1'b0;
        wait_rsp(200);
        chk ("stall_nfrm", nfrm - base, 2);
        chk ("stall_frame_hdr", frm_word[base], 32'h00010000);
        chk ("stall_rdata", rsp_rdata, 32'h11112222);
        tick();

        // Reset while the data frame is in flight
        base = nfrm;
        send_req(1'b1, 15'h0ABC, 32'h01020304);
        for (int i = 0; i < 200 && !(nfrm == base + 1 && spi_busy === 1'b1); i++) tick();
        chkb("dw_reached", (nfrm == base + 1) && (spi_busy === 1'b1), 1'b1);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chkb("abort_req_ready", req_ready, 1'b0);
        chkb("abort_rsp_valid", rsp_valid, 1'b0);
        chkb("abort_rsp_err", rsp_err, 1'b0);
        chkb("abort_spi_load", spi_load, 1'b0);
        chk ("abort_rsp_rdata", rsp_rdata, 32'h0);
        chk ("abort_spi_data_in", spi_data_in, 32'h0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        chkb("abort_no_rsp", seen, 1'b0);
        chk ("abort_nfrm", nfrm - base, 1);

        // Normal transaction after the abort
        base = nfrm; slave_resp = 32'h0F0F0F0F;
        send_req(1'b0, 15'h0042, 32'h0);
        wait_rsp(200);
        chk ("post_rdata", rsp_rdata, 32'h0F0F0F0F);
        chk ("post_hdr", frm_word[base], 32'h00420000);
        chkb("post_err", rsp_err, 1'b0);
        tick();

`ifdef HS_SPI_TXN_TIMEOUT_EN
        // Busy stuck high: watchdog ends the header wait
        stuck_busy = 1'b1; base = nfrm;
        send_req(1'b1, 15'h0010, 32'hAAAA5555);
        wait_rsp(300);
        t_rsp = cyc;
        chk ("tmo_cycles", t_rsp - (frm_acc[base] + 1), TMO);
        chkb("tmo_err", rsp_err, 1'b1);
        chk ("tmo_rdata", rsp_rdata, 32'h0);
        stuck_busy = 1'b0;
        tick();
        tick();
`else
        t_rsp = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
